// File: rtl/pipelined_circular_shift.sv
// pipelined_circular_shift
//
// Pipelined, back-pressured rotator for a SIZE-element list of WIDTH-bit elements.
// SIZE need not be a power of two. Shift amounts may be anywhere in 0..2^SHW-1 and
// are reduced modulo SIZE on entry. Both rotate directions are supported. A sideband
// tag travels alongside each vector. The block sustains one vector per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; clears all data, tags and valid bits
//   in_valid   input vector valid
//   in_ready   block can accept the input vector this cycle
//   in_list    input vector, element i at [i*WIDTH +: WIDTH]
//   in_shift   rotate amount, 0..2^SHW-1
//   in_dir     0: out[i] = in[(i-s) mod SIZE], 1: out[i] = in[(i+s) mod SIZE]
//   in_tag     sideband tag, emerges unchanged with its vector
//   out_valid  output vector valid
//   out_ready  downstream accepts the output vector
//   out_list   rotated vector
//   out_tag    tag of the output vector
//
// Structure
//   Register 0 captures the vector, tag and a normalised shift. The normalised
//   shift always describes an out[i] = in[(i-s') mod SIZE] rotation, so the later
//   stages only rotate in one direction. Rotate stage k conditionally rotates by
//   (2^k mod SIZE). A register follows every PIPE_EVERY rotate stages and the last
//   stage, giving L registers in total. With no backpressure a vector presented
//   in cycle c appears on the outputs in cycle c+L.
module pipelined_circular_shift #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIZE       = 257,
  parameter int unsigned PIPE_EVERY = 3,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE*WIDTH-1:0]   in_list,
  input  logic [$clog2(SIZE)-1:0] in_shift,
  input  logic                    in_dir,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE*WIDTH-1:0]   out_list,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int unsigned SHW  = $clog2(SIZE);
  localparam int unsigned NSTG = SHW;
  // Input register plus one register per group of PIPE_EVERY rotate stages.
  localparam int unsigned L    = 1 + (NSTG + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int unsigned VW   = SIZE * WIDTH;

  // SIZE widened by one bit: for a power-of-two SIZE it does not fit in SHW bits.
  localparam logic [SHW:0] SizeExt = (SHW+1)'(SIZE);

  // ---------------------------------------------------------------------------
  // Shift normalisation ahead of register 0
  // ---------------------------------------------------------------------------
  logic [SHW:0]   shift_ext;
  logic [SHW:0]   shift_red;
  logic [SHW-1:0] shift_norm;

  // 2^SHW < 2*SIZE, so a single conditional subtract reduces modulo SIZE.
  always_comb begin
    shift_ext = {1'b0, in_shift};
    shift_red = (shift_ext >= SizeExt) ? (shift_ext - SizeExt) : shift_ext;
    if (in_dir && (shift_red != '0)) begin
      // Rotating by s one way equals rotating by SIZE-s the other way.
      shift_norm = SHW'(SizeExt - shift_red);
    end else begin
      shift_norm = shift_red[SHW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [VW-1:0]    data_q  [L];
  logic [TAG_W-1:0] tag_q   [L];
  // The last register has no rotate stages after it, so it carries no shift.
  logic [SHW-1:0]   shift_q [L-1];
  logic [L-1:0]     valid_q;
  logic [L-1:0]     load;

  // Combinational output of each group of rotate stages, feeding register r+1.
  logic [VW-1:0]    blk_out [L-1];

  // ---------------------------------------------------------------------------
  // Rotate network
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NSTG; k++) begin : g_rot
    localparam int unsigned Blk = k / PIPE_EVERY;
    localparam int unsigned Amt = (32'd1 << k) % SIZE;

    logic [VW-1:0] din;
    logic [VW-1:0] dout;
    logic          en;

    // The first stage of each group reads a register; the others chain.
    if (k % PIPE_EVERY == 0) begin : g_head
      assign din = data_q[Blk];
    end else begin : g_chain
      assign din = g_rot[k-1].dout;
    end

    assign en = shift_q[Blk][k];

    always_comb begin
      dout = din;
      if (en) begin
        for (int i = 0; i < SIZE; i++) begin
          dout[i*WIDTH +: WIDTH] = din[((i + SIZE - Amt) % SIZE)*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < L - 1; r++) begin : g_blk
    localparam int unsigned End  = (r + 1) * PIPE_EVERY;
    localparam int unsigned Last = ((End < NSTG) ? End : NSTG) - 1;
    assign blk_out[r] = g_rot[Last].dout;
  end

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Register r loads when it is empty or register r+1 loads (the last one when
  // downstream is ready). Unrolled, load[r] is out_ready OR any empty register
  // at or after r, which is evaluated from the output end backwards.
  always_comb begin : p_load
    logic acc;
    load = '0;
    acc  = out_ready;
    for (int r = L - 1; r >= 0; r--) begin
      acc     = acc | ~valid_q[r];
      load[r] = acc;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int r = 0; r < L; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      for (int r = 0; r < L - 1; r++) begin
        shift_q[r] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0]  <= in_list;
          tag_q[0]   <= in_tag;
          shift_q[0] <= shift_norm;
        end
      end
      for (int r = 1; r < L; r++) begin
        if (load[r]) begin
          valid_q[r] <= valid_q[r-1];
          if (valid_q[r-1]) begin
            data_q[r] <= blk_out[r-1];
            tag_q[r]  <= tag_q[r-1];
          end
        end
      end
      for (int r = 1; r < L - 1; r++) begin
        if (load[r] && valid_q[r-1]) begin
          shift_q[r] <= shift_q[r-1];
        end
      end
    end
  end

  // Bits of shift_q below the group's first stage are never consumed.
  logic unused_shift;
  always_comb begin
    unused_shift = 1'b0;
    for (int r = 0; r < L - 1; r++) begin
      unused_shift = unused_shift ^ (^shift_q[r]);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = valid_q[L-1];
  assign out_list  = data_q[L-1];
  assign out_tag   = tag_q[L-1];

  // A stalled output must hold its vector and tag until it is taken.
  a_stall_hold : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_list) && $stable(out_tag))
  );

endmodule

// File: tb/tb_pipelined_circular_shift.sv
module tb_pipelined_circular_shift;

  localparam int W   = 32;
  localparam int N   = 257;
  localparam int SHW = 9;
  localparam int PE  = 3;
  localparam int TW  = 8;
  localparam int VW  = W * N;
  localparam int LAT = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [VW-1:0]  in_list;
  logic [SHW-1:0] in_shift;
  logic           in_dir;
  logic [TW-1:0]  in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [VW-1:0]  out_list;
  logic [TW-1:0]  out_tag;

  pipelined_circular_shift #(
    .WIDTH     (W),
    .SIZE      (N),
    .PIPE_EVERY(PE),
    .TAG_W     (TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_list  (in_list),
    .in_shift (in_shift),
    .in_dir   (in_dir),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_list (out_list),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int nout  = 0;
  int last_tin = 0;

  typedef struct {
    logic [VW-1:0] v;
    logic [TW-1:0] tag;
    int            t_in;
    bit            lat;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One comparison per vector, reporting the lowest differing element.
  task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    int bad;
    bad = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (got[i*W +: W] !== exp[i*W +: W]) bad = i;
    end
    check($sformatf("%s[%0d]", tag, bad), 64'(got[bad*W +: W]), 64'(exp[bad*W +: W]));
  endtask

  // Reference: reduce the amount modulo N, then index with modular arithmetic.
  function automatic logic [VW-1:0] rot_model(input logic [VW-1:0] v, input logic [SHW-1:0] sh,
                                              input bit d);
    logic [VW-1:0] r;
    int s;
    int src;
    s = int'(sh) % N;
    for (int i = 0; i < N; i++) begin
      src = d ? (i + s) % N : (i - s + N) % N;
      r[i*W +: W] = v[src*W +: W];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] elem(input int i);
    return 64'(out_list[i*W +: W]);
  endfunction

  // Output monitor: every output transfer is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check_vec("out_list", out_list, e.v);
        check("out_tag", 64'(out_tag), 64'(e.tag));
        if (e.lat) check("latency", 64'(cyc - e.t_in), 64'(LAT));
      end
      nout++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [VW-1:0] v, input logic [SHW-1:0] sh, input bit d,
                      input logic [TW-1:0] tg, input bit lat);
    bit ok;
    ok = 1'b0;
    in_list  = v;
    in_shift = sh;
    in_dir   = d;
    in_tag   = tg;
    in_valid = 1'b1;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{rot_model(v, sh, d), tg, cyc, lat});
        last_tin = cyc;
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Returns at the negedge on which out_valid is first seen.
  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("out_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_drain();
    for (int b = 0; b < 200; b++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  logic [VW-1:0] idv;

  // Directed single vector of identity elements with two element checks.
  task automatic run_fixed(input string nm, input logic [SHW-1:0] sh, input bit d,
                           input int i0, input int e0, input int i1, input int e1);
    send(idv, sh, d, 8'h20, 1'b1);
    wait_out();
    check({nm, "_a"}, elem(i0), 64'(e0));
    check({nm, "_b"}, elem(i1), 64'(e1));
    @(posedge clk); #1;
  endtask

  logic [VW-1:0]  t5v [6];
  logic [SHW-1:0] t5s [6];
  bit             t5d [6];
  int             acc;

  task automatic t5_offer(input int cycles);
    for (int c = 0; c < cycles && acc < 6; c++) begin
      in_valid = 1'b1;
      in_list  = t5v[acc];
      in_shift = t5s[acc];
      in_dir   = t5d[acc];
      in_tag   = 8'(acc + 'h50);
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{rot_model(t5v[acc], t5s[acc], t5d[acc]), 8'(acc + 'h50), cyc, 1'b0});
        acc++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n0;
    in_valid  = 1'b0;
    in_list   = '0;
    in_shift  = '0;
    in_dir    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) idv[i*W +: W] = W'(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check_vec("rst_out_list", out_list, '0);
    check("rst_out_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // T1: identity with exact latency.
    send(idv, 9'd0, 1'b0, 8'h11, 1'b1);
    wait_out();
    check("t1_latency", 64'(cyc - last_tin), 64'(LAT));
    check_vec("t1_identity", out_list, idv);
    @(posedge clk); #1;

    // T2/T3: small and large amounts in both directions.
    run_fixed("t2_r1", 9'd1,   1'b0, 0, 256, 256, 255);
    run_fixed("t2_l1", 9'd1,   1'b1, 0, 1,   256, 0);
    run_fixed("t3_300", 9'd300, 1'b0, 0, 214, 43,  0);
    run_fixed("t3_511", 9'd511, 1'b1, 0, 254, 3,   0);
    run_fixed("t3_257", 9'd257, 1'b1, 0, 0,   100, 100);

    // T4: back-to-back random stream.
    n0 = nout;
    for (int i = 0; i < 20; i++) begin
      send(rand_vec(), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 8'(i), 1'b1);
    end
    wait_drain();
    check("t4_count", 64'(nout - n0), 64'(20));

    // T5: backpressure fills the pipeline, then drains in order.
    for (int k = 0; k < 6; k++) begin
      t5v[k] = rand_vec();
      t5s[k] = 9'($urandom_range(0, 511));
      t5d[k] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    acc = 0;
    n0  = nout;
    t5_offer(10);
    check("t5_accepted", 64'(acc), 64'(4));
    check("t5_in_ready_low", 64'(in_ready), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_stall_valid", 64'(out_valid), 64'(1));
      if (q.size() > 0) begin
        check_vec("t5_stall_list", out_list, q[0].v);
        check("t5_stall_tag", 64'(out_tag), 64'(q[0].tag));
      end else begin
        check("t5_queue", 64'(0), 64'(1));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t5_offer(40);
    in_valid = 1'b0;
    check("t5_all_sent", 64'(acc), 64'(6));
    wait_drain();
    check("t5_count", 64'(nout - n0), 64'(6));

    // T6: reset with vectors in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(rand_vec(), 9'(k * 7), 1'b0, 8'(k + 'h60), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_full_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'(0));
    check_vec("t6_rst_list", out_list, '0);
    check("t6_rst_tag", 64'(out_tag), 64'(0));
    q.delete();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_in_ready", 64'(in_ready), 64'(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    send(idv, 9'd5, 1'b0, 8'h6a, 1'b1);
    wait_out();
    check("t6_latency", 64'(cyc - last_tin), 64'(LAT));
    check("t6_elem0", elem(0), 64'(252));
    check("t6_tag", 64'(out_tag), 64'(8'h6a));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
